ft_error_detector: RTL and testbench

//  Upstream stage of the recovery control block. Compares the register write-back

---
 rtl/ft_error_detector.sv | 232 +++++++++++++++++++++++
 tb/tb_ft_error_detector.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ft_error_detector.sv
// ft_error_detector
// Lockstep (DMR) write-back comparator feeding the recovery control block.
// A divergence between the two cores' register write-back buses raises a
// single-cycle error pulse that starts register replay. Comparison is masked
// while recovery is in progress (fetch_block_i). A repeat divergence inside the
// post-recovery guard window, or a missing recovery acknowledge, latches a
// sticky permanent-fault flag.
//
// Timing: stage 1 registers both buses; stage 2 compares the registered buses
// and steers the FSM. The FSM enters REPORT on that edge, so a divergence
// presented in cycle N shows up as error_o in cycle N+2.
module ft_error_detector #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 5,
   parameter int PERSIST_WINDOW = 16,
   parameter int ACK_TIMEOUT    = 4,
   parameter int CNT_WIDTH      = 8
) (
   input  logic                  clk,
   input  logic                  rst_i,
   input  logic                  core0_we_i,
   input  logic [ADDR_WIDTH-1:0] core0_waddr_i,
   input  logic [DATA_WIDTH-1:0] core0_wdata_i,
   input  logic                  core1_we_i,
   input  logic [ADDR_WIDTH-1:0] core1_waddr_i,
   input  logic [DATA_WIDTH-1:0] core1_wdata_i,
   input  logic                  fetch_block_i,
   output logic                  error_o,
   output logic                  fault_permanent_o,
   output logic [CNT_WIDTH-1:0]  error_count_o
);

   // Counter widths sized so the load values fit.
   localparam int GUARD_W = $clog2(PERSIST_WINDOW + 1);
   localparam int TMO_W   = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [2:0] {
      MONITOR  = 3'd0,
      REPORT   = 3'd1,
      WAIT_ACK = 3'd2,
      RECOVER  = 3'd3,
      GUARD    = 3'd4,
      HALT     = 3'd5
   } state_t;

   // Saturating increment for the error counter: sticks at all-ones.
   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      if (&v) begin
         return v;
      end
      return v + CNT_WIDTH'(1);
   endfunction

   // Two write-back beats disagree if only one core writes, or both write
   // with a different address or value. Idle beats never disagree.
   function automatic logic wb_differs(
      input logic                  we0,
      input logic [ADDR_WIDTH-1:0] addr0,
      input logic [DATA_WIDTH-1:0] data0,
      input logic                  we1,
      input logic [ADDR_WIDTH-1:0] addr1,
      input logic [DATA_WIDTH-1:0] data1
   );
      return (we0 != we1) | (we0 & we1 & ((addr0 != addr1) | (data0 != data1)));
   endfunction

   state_t state;
   state_t next_state;

   logic                  we0_p1;
   logic [ADDR_WIDTH-1:0] waddr0_p1;
   logic [DATA_WIDTH-1:0] wdata0_p1;
   logic                  we1_p1;
   logic [ADDR_WIDTH-1:0] waddr1_p1;
   logic [DATA_WIDTH-1:0] wdata1_p1;
   logic                  vld_p1;

   logic                  mismatch_p2;
   logic                  flush;
   logic                  count_inc;
   logic                  fault_set;
   logic                  tmo_clr;
   logic                  tmo_inc;
   logic                  guard_load;
   logic                  guard_dec;

   logic [TMO_W-1:0]      tmo_cnt;
   logic [GUARD_W-1:0]    guard_cnt;
   logic [CNT_WIDTH-1:0]  err_cnt;
   logic                  fault_reg;

   // ---- stage 1: capture both write-back buses ----
   // A beat captured while recovery is active, or on a flush edge, is marked
   // invalid so it can never be compared later.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         vld_p1    <= 1'b0;
         we0_p1    <= 1'b0;
         waddr0_p1 <= '0;
         wdata0_p1 <= '0;
         we1_p1    <= 1'b0;
         waddr1_p1 <= '0;
         wdata1_p1 <= '0;
      end else begin
         vld_p1    <= ~fetch_block_i & ~flush;
         we0_p1    <= core0_we_i;
         waddr0_p1 <= core0_waddr_i;
         wdata0_p1 <= core0_wdata_i;
         we1_p1    <= core1_we_i;
         waddr1_p1 <= core1_waddr_i;
         wdata1_p1 <= core1_wdata_i;
      end
   end

   // ---- stage 2: compare registered buses, masked during recovery ----
   assign mismatch_p2 = vld_p1 & ~fetch_block_i &
                        wb_differs(we0_p1, waddr0_p1, wdata0_p1,
                                   we1_p1, waddr1_p1, wdata1_p1);

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         state <= MONITOR;
      end else begin
         state <= next_state;
      end
   end

   // FSM next-state and control strobes.
   always_comb begin
      next_state = state;
      flush      = 1'b0;
      count_inc  = 1'b0;
      tmo_clr    = 1'b0;
      tmo_inc    = 1'b0;
      guard_load = 1'b0;
      guard_dec  = 1'b0;
      unique case (state)
         MONITOR: begin
            if (mismatch_p2) begin
               next_state = REPORT;
            end
         end
         REPORT: begin
            // Single pulse cycle; discard whatever was in flight behind it.
            count_inc  = 1'b1;
            flush      = 1'b1;
            tmo_clr    = 1'b1;
            next_state = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (fetch_block_i) begin
               next_state = RECOVER;
            end else if (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1)) begin
               next_state = HALT;
            end else begin
               tmo_inc = 1'b1;
            end
         end
         RECOVER: begin
            if (!fetch_block_i) begin
               flush      = 1'b1;
               guard_load = 1'b1;
               next_state = GUARD;
            end
         end
         GUARD: begin
            // A mismatch wins over window expiry in the same cycle.
            if (mismatch_p2) begin
               next_state = HALT;
            end else if (guard_cnt <= GUARD_W'(1)) begin
               next_state = MONITOR;
            end else begin
               guard_dec = 1'b1;
            end
         end
         HALT: begin
            next_state = HALT;
         end
         default: begin
            next_state = MONITOR;
         end
      endcase
   end

   assign fault_set = (next_state == HALT) & (state != HALT);

   // Acknowledge timeout counter, cleared while reporting.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         tmo_cnt <= '0;
      end else if (tmo_clr) begin
         tmo_cnt <= '0;
      end else if (tmo_inc) begin
         tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
   end

   // Post-recovery guard window counter.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         guard_cnt <= '0;
      end else if (guard_load) begin
         guard_cnt <= GUARD_W'(PERSIST_WINDOW);
      end else if (guard_dec) begin
         guard_cnt <= guard_cnt - GUARD_W'(1);
      end
   end

   // Saturating count of issued error pulses.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         err_cnt <= '0;
      end else if (count_inc) begin
         err_cnt <= sat_inc(err_cnt);
      end
   end

   // Sticky permanent-fault flag, set on the edge that enters HALT.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         fault_reg <= 1'b0;
      end else if (fault_set) begin
         fault_reg <= 1'b1;
      end
   end

   assign error_o           = (state == REPORT);
   assign fault_permanent_o = fault_reg;
   assign error_count_o     = err_cnt;

endmodule

// File: tb/tb_ft_error_detector.sv
// tb_ft_error_detector
// Drives both a default instance and a CNT_WIDTH=2 instance with the same
// stimulus and checks every cycle against an event-level reference model.
module tb_ft_error_detector;
   localparam int AW = 5;
   localparam int DW = 32;
   localparam int PW = 16;
   localparam int AT = 4;

   localparam int M_WATCH   = 0;
   localparam int M_PULSE   = 1;
   localparam int M_WAITING = 2;
   localparam int M_RECOVER = 3;
   localparam int M_GUARD   = 4;
   localparam int M_HALTED  = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          we0, we1, fb;
   logic [AW-1:0] a0, a1;
   logic [DW-1:0] d0, d1;
   logic          err, fault, err2, fault2;
   logic [7:0]    cnt;
   logic [1:0]    cnt2;

   int total = 0;
   int bad   = 0;

   // reference model
   int mode, wait_left, guard_left, ign, t, m_cnt8, m_cnt2;
   bit m_fault, prev_mm, prev_fb;

   // random agent state
   int ack_wait, hold, halt_age;

   always #5 clk = ~clk;

   ft_error_detector #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PERSIST_WINDOW(PW),
                       .ACK_TIMEOUT(AT), .CNT_WIDTH(8)) u_dut (
      .clk(clk), .rst_i(rst),
      .core0_we_i(we0), .core0_waddr_i(a0), .core0_wdata_i(d0),
      .core1_we_i(we1), .core1_waddr_i(a1), .core1_wdata_i(d1),
      .fetch_block_i(fb), .error_o(err), .fault_permanent_o(fault),
      .error_count_o(cnt));

   ft_error_detector #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PERSIST_WINDOW(PW),
                       .ACK_TIMEOUT(AT), .CNT_WIDTH(2)) u_dut2 (
      .clk(clk), .rst_i(rst),
      .core0_we_i(we0), .core0_waddr_i(a0), .core0_wdata_i(d0),
      .core1_we_i(we1), .core1_waddr_i(a1), .core1_wdata_i(d1),
      .fetch_block_i(fb), .error_o(err2), .fault_permanent_o(fault2),
      .error_count_o(cnt2));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, t, got, exp);
      end
   endtask

   // One clock cycle: drive, check outputs against the model, advance the model.
   task automatic cyc(input logic w0, input logic [AW-1:0] ad0, input logic [DW-1:0] dd0,
                      input logic w1, input logic [AW-1:0] ad1, input logic [DW-1:0] dd1,
                      input logic f, input logic r);
      bit cur_mm, seen;
      @(posedge clk);
      #1;
      we0 = w0; a0 = ad0; d0 = dd0;
      we1 = w1; a1 = ad1; d1 = dd1;
      fb = f; rst = r;
      @(negedge clk);
      chk("error_o",    32'(err),    32'(mode == M_PULSE));
      chk("fault",      32'(fault),  32'(m_fault));
      chk("count8",     32'(cnt),    32'(m_cnt8));
      chk("error_o_w2", 32'(err2),   32'(mode == M_PULSE));
      chk("fault_w2",   32'(fault2), 32'(m_fault));
      chk("count2",     32'(cnt2),   32'(m_cnt2));
      cur_mm = (w0 != w1) || (w0 && w1 && (ad0 != ad1 || dd0 != dd1));
      seen   = (t - 1 >= ign) && prev_mm && !prev_fb && !f;
      if (r) begin
         mode = M_WATCH; m_cnt8 = 0; m_cnt2 = 0; m_fault = 0; ign = t + 1;
      end else begin
         case (mode)
            M_WATCH: if (seen) mode = M_PULSE;
            M_PULSE: begin
               if (m_cnt8 < 255) m_cnt8++;
               if (m_cnt2 < 3) m_cnt2++;
               wait_left = AT;
               ign = t + 1;
               mode = M_WAITING;
            end
            M_WAITING: begin
               if (f) mode = M_RECOVER;
               else begin
                  wait_left--;
                  if (wait_left == 0) begin mode = M_HALTED; m_fault = 1; end
               end
            end
            M_RECOVER: if (!f) begin mode = M_GUARD; guard_left = PW; ign = t + 1; end
            M_GUARD: begin
               if (seen) begin mode = M_HALTED; m_fault = 1; end
               else begin
                  guard_left--;
                  if (guard_left == 0) mode = M_WATCH;
               end
            end
            default: ;
         endcase
      end
      prev_mm = cur_mm;
      prev_fb = f;
      t++;
   endtask

   // Identical write-back on both cores; idle beats carry unrelated addr/data.
   task automatic clean(input logic f, input logic r = 1'b0);
      logic          w;
      logic [AW-1:0] ad;
      logic [DW-1:0] dd;
      w  = 1'($urandom);
      ad = AW'($urandom);
      dd = $urandom;
      if (w) cyc(w, ad, dd, w, ad, dd, f, r);
      else   cyc(1'b0, ad, dd, 1'b0, ad ^ AW'($urandom), $urandom, f, r);
   endtask

   // One divergent beat of a random kind.
   task automatic diverge(input logic f);
      logic [AW-1:0] ad;
      logic [DW-1:0] dd;
      int k;
      ad = AW'($urandom);
      dd = $urandom;
      k  = int'($urandom % 3);
      case (k)
         0:       cyc(1'b1, ad, dd, 1'b0, ad, dd, f, 1'b0);
         1:       cyc(1'b1, ad, dd, 1'b1, ad ^ AW'(1 + $urandom % 31), dd, f, 1'b0);
         default: cyc(1'b1, ad, dd, 1'b1, ad, dd ^ (32'd1 << ($urandom % 32)), f, 1'b0);
      endcase
   endtask

   // Error, prompt acknowledge, short recovery, full clean guard window.
   task automatic error_and_recover();
      diverge(1'b0);
      repeat (2) clean(1'b0);
      repeat (3) clean(1'b1);
      repeat (18) clean(1'b0);
   endtask

   initial begin
      logic f, r;
      mode = M_WATCH; wait_left = 0; guard_left = 0; ign = 0; t = 0;
      m_cnt8 = 0; m_cnt2 = 0; m_fault = 0; prev_mm = 0; prev_fb = 0;
      ack_wait = 0; hold = 0; halt_age = 0;
      rst = 1'b1; fb = 1'b0; we0 = 1'b0; we1 = 1'b0;
      a0 = '0; a1 = '0; d0 = '0; d1 = '0;
      repeat (2) @(posedge clk);

      // identical random streams, including idle beats with differing addr/data
      repeat (100) clean(1'b0);
      chk("s1_count", 32'(cnt), 32'd0);

      // data 0x0 vs 0x1, acknowledged, divergences while masked, clean guard
      cyc(1'b1, 5'd4, 32'h0, 1'b1, 5'd4, 32'h1, 1'b0, 1'b0);
      repeat (2) clean(1'b0);
      for (int i = 0; i < 32; i++) begin
         if (i % 3 == 0) diverge(1'b1);
         else clean(1'b1);
      end
      repeat (17) clean(1'b0);
      chk("s2_count", 32'(cnt), 32'd1);
      chk("s2_fault", 32'(fault), 32'd0);

      // repeat divergence three cycles after recovery ends
      diverge(1'b0);
      repeat (2) clean(1'b0);
      repeat (5) clean(1'b1);
      repeat (3) clean(1'b0);
      diverge(1'b0);
      repeat (6) clean(1'b0);
      chk("s4_fault", 32'(fault), 32'd1);
      chk("s4_count", 32'(cnt), 32'd2);

      // write-enable divergence with no acknowledge
      clean(1'b0, 1'b1);
      cyc(1'b1, 5'd3, 32'h55, 1'b0, 5'd3, 32'h55, 1'b0, 1'b0);
      repeat (8) clean(1'b0);
      chk("s5_fault", 32'(fault), 32'd1);
      chk("s5_count", 32'(cnt), 32'd1);

      // reset in the middle of recovery, then normal reporting and saturation
      clean(1'b0, 1'b1);
      diverge(1'b0);
      repeat (2) clean(1'b0);
      repeat (3) clean(1'b1);
      clean(1'b1, 1'b1);
      clean(1'b0);
      chk("s6_rst_count", 32'(cnt), 32'd0);
      chk("s6_rst_fault", 32'(fault), 32'd0);
      repeat (6) error_and_recover();
      chk("s6_count8", 32'(cnt), 32'd6);
      chk("s6_count2", 32'(cnt2), 32'd3);

      // free-running random traffic with a randomly slow recovery agent
      for (int i = 0; i < 3000; i++) begin
         r = 1'b0;
         case (mode)
            M_PULSE: begin
               ack_wait = int'($urandom % 6);
               hold = int'($urandom % 20);
               f = 1'b0;
            end
            M_WAITING: begin
               if (ack_wait == 0) f = 1'b1;
               else begin ack_wait--; f = 1'b0; end
            end
            M_RECOVER: begin
               if (hold > 0) begin hold--; f = 1'b1; end
               else f = 1'b0;
            end
            M_HALTED: begin
               f = 1'b0;
               halt_age++;
               if (halt_age > 3) begin r = 1'b1; halt_age = 0; end
            end
            default: f = ($urandom % 20 == 0);
         endcase
         if ($urandom % 400 == 0) r = 1'b1;
         if (!r && $urandom % 10 == 0) diverge(f);
         else clean(f, r);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
